// File: rtl/mem_access_unit.sv
// Data-memory access unit: one outstanding load/store, byte-lane stores, load extraction with timeout.
// Define MEMACC_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  MemWrite,
    input  logic [2:0]  Mask,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } stateT;

    localparam logic [1:0] MW_LOAD = 2'b00;
    localparam logic [1:0] MW_SB   = 2'b01;
    localparam logic [1:0] MW_SH   = 2'b10;
    localparam logic [1:0] MW_SW   = 2'b11;

    localparam logic [2:0] MK_LB   = 3'b000;
    localparam logic [2:0] MK_LH   = 3'b001;
    localparam logic [2:0] MK_LW   = 3'b010;
    localparam logic [2:0] MK_LBU  = 3'b011;
    localparam logic [2:0] MK_LHU  = 3'b100;

`ifdef MEMACC_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    stateT          state;
    logic [CW-1:0]  waitCnt;
    logic           regLoad;
    logic [2:0]     regMask;
    logic [1:0]     regOff;

    logic           isLoad;
    logic           isHalf;
    logic           isWord;
    logic           maskIllegal;
    logic           misaligned;
    logic           reqErr;
    logic [1:0]     effOff;

    function automatic logic [3:0] storeEnables(input logic [1:0] mw, input logic [1:0] off);
        logic [3:0] we;
        case (mw)
            MW_SB:   we = 4'b1000 >> off;
            MW_SH:   we = off[1] ? 4'b0011 : 4'b1100;
            MW_SW:   we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] storeData(input logic [1:0] mw, input logic [31:0] wd);
        logic [31:0] d;
        case (mw)
            MW_SB:   d = {4{wd[7:0]}};
            MW_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] loadExtract(input logic [2:0] mk, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rd[31:24];
            2'd1:    b = rd[23:16];
            2'd2:    b = rd[15:8];
            default: b = rd[7:0];
        endcase
        h = off[1] ? rd[15:0] : rd[31:16];
        case (mk)
            MK_LB:   r = {{24{b[7]}}, b};
            MK_LH:   r = {{16{h[15]}}, h};
            MK_LBU:  r = {24'd0, b};
            MK_LHU:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // Decode the incoming request: size class, legality and the lane offset actually used.
    always_comb begin
        isLoad      = (MemWrite == MW_LOAD);
        maskIllegal = isLoad && (Mask > MK_LHU);
        isHalf      = (isLoad && (Mask == MK_LH || Mask == MK_LHU)) || (MemWrite == MW_SH);
        isWord      = (isLoad && (Mask == MK_LW)) || (MemWrite == MW_SW);
        misaligned  = (isHalf && addr[0]) || (isWord && (addr[1:0] != 2'b00));
        reqErr      = maskIllegal || (TRAP_MISALIGN && misaligned);
        effOff      = addr[1:0];
        if (isHalf)
            effOff[0] = 1'b0;
        if (isWord)
            effOff = 2'b00;
    end

    assign req_ready = (state == IDLE);

    // Response fields are only non-zero during the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            waitCnt    <= '0;
            regLoad    <= 1'b0;
            regMask    <= 3'd0;
            regOff     <= 2'd0;
            mem_en     <= 1'b0;
            mem_we     <= 4'b0000;
            mem_addr   <= 30'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        regLoad <= isLoad;
                        regMask <= Mask;
                        regOff  <= effOff;
                        if (reqErr) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'd0;
                            state      <= RESP;
                        end else begin
                            mem_en   <= 1'b1;
                            mem_addr <= addr[31:2];
                            if (isLoad) begin
                                mem_we <= 4'b0000;
                            end else begin
                                mem_we    <= storeEnables(MemWrite, effOff);
                                mem_wdata <= storeData(MemWrite, wdata);
                            end
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 4'b0000;
                    if (regLoad) begin
                        waitCnt <= '0;
                        state   <= WAIT;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= 32'd0;
                        state      <= RESP;
                    end
                end
                WAIT: begin
                    // Read data takes priority over a timeout landing in the same cycle.
                    if (mem_rvalid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_data  <= loadExtract(regMask, regOff, mem_rdata);
                        state      <= RESP;
                    end else if (waitCnt == CNT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_data  <= 32'd0;
                        state      <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; honours MEMACC_MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  MemWrite;
    logic [2:0]  Mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .MemWrite(MemWrite), .Mask(Mask), .addr(addr), .wdata(wdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } expT;

    expT expQ[$];
    int  assertCount = 0;
    int  failCount   = 0;
    int  cyc         = 0;
    int  memEnCount  = 0;
    int  txnId       = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Pops the expected response whenever the DUT pulses resp_valid.
    always @(negedge clk) begin
        expT e;
        if (mem_en)
            memEnCount++;
        if (rst_n && resp_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("t%0d_data", e.id), resp_data, e.data);
                checkOutput($sformatf("t%0d_err", e.id), {31'd0, resp_err}, {31'd0, e.err});
                checkOutput($sformatf("t%0d_cycle", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic logic [31:0] modelLoad(input logic [2:0] mk, input logic [1:0] off,
                                              input logic [31:0] rd);
        int          bs;
        int          hs;
        logic [31:0] b;
        logic [31:0] h;
        bs = 8 * (3 - int'(off));
        hs = off[1] ? 0 : 16;
        b  = (rd >> bs) & 32'h0000_00FF;
        h  = (rd >> hs) & 32'h0000_FFFF;
        case (mk)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd2:    return rd;
            3'd3:    return b;
            3'd4:    return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelStore(input logic [1:0] mw, input logic [1:0] off, input logic [31:0] wd,
                              output logic [3:0] we, output logic [31:0] d);
        we = 4'b0000;
        d  = wd;
        if (mw == 2'b01) begin
            we[3 - int'(off)] = 1'b1;
            d = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        end else if (mw == 2'b10) begin
            we = (off >= 2'd2) ? 4'b0011 : 4'b1100;
            d  = {wd[15:0], wd[15:0]};
        end else if (mw == 2'b11) begin
            we = 4'b1111;
        end
    endtask

    // Drives one request, checks the memory strobe, supplies read data after lat cycles (lat<1: never).
    task automatic applyStimulus(input logic [1:0] mw, input logic [2:0] mk, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int lat,
                                 input bit expAccess, input logic [29:0] expAddr,
                                 input logic [3:0] expWe, input logic [31:0] expWdata,
                                 input logic [31:0] expData, input logic expErr);
        int guard;
        int rc;
        int startEn;
        expT e;
        if (!expAccess)                   rc = 1;
        else if (mw != 2'b00)             rc = 2;
        else if (lat >= 1 && lat <= TO)  rc = 2 + lat;
        else                              rc = 2 + TO;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready)
            checkOutput("ready_wait", 32'd0, 32'd1);
        txnId++;
        req_valid = 1'b1;
        MemWrite  = mw;
        Mask      = mk;
        addr      = a;
        wdata     = wd;
        e.id   = txnId;
        e.data = expData;
        e.err  = expErr;
        e.cyc  = cyc + rc;
        expQ.push_back(e);
        startEn = memEnCount;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (expAccess) begin
            checkOutput($sformatf("t%0d_mem_en", txnId), {31'd0, mem_en}, 32'd1);
            checkOutput($sformatf("t%0d_mem_addr", txnId), {2'd0, mem_addr}, {2'd0, expAddr});
            checkOutput($sformatf("t%0d_mem_we", txnId), {28'd0, mem_we}, {28'd0, expWe});
            if (mw != 2'b00)
                checkOutput($sformatf("t%0d_mem_wdata", txnId), mem_wdata, expWdata);
            if (mw == 2'b00 && lat >= 1) begin
                repeat (lat) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
                @(posedge clk);
                #1 mem_rvalid = 1'b0;
            end
        end
        guard = 0;
        while (expQ.size() != 0 && guard < TO + 20) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() != 0) begin
            checkOutput($sformatf("t%0d_resp_missing", txnId), 32'd0, 32'd1);
            expQ.delete();
        end
        @(negedge clk);
        checkOutput($sformatf("t%0d_ready_after", txnId), {31'd0, req_ready}, 32'd1);
        checkOutput($sformatf("t%0d_mem_en_count", txnId), 32'(memEnCount - startEn),
                    expAccess ? 32'd1 : 32'd0);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        checkOutput({pfx, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        checkOutput({pfx, "_mem_we"}, {28'd0, mem_we}, 32'd0);
        checkOutput({pfx, "_mem_addr"}, {2'd0, mem_addr}, 32'd0);
        checkOutput({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({pfx, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({pfx, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        checkOutput({pfx, "_resp_data"}, resp_data, 32'd0);
    endtask

    initial begin
        logic [1:0]  mw;
        logic [2:0]  mk;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [3:0]  we;
        logic [31:0] sd;
        logic [31:0] ed;
        int          lat;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        MemWrite   = 2'b00;
        Mask       = 3'b000;
        addr       = 32'd0;
        wdata      = 32'd0;
        mem_rdata  = 32'd0;
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        $display("[TB] directed stores and loads");
        applyStimulus(2'b01, 3'd0, 32'h0000_1001, 32'h0000_00AB, 32'd0, 0,
                      1'b1, 30'h400, 4'b0100, 32'hABAB_ABAB, 32'd0, 1'b0);
        applyStimulus(2'b10, 3'd0, 32'h0000_0012, 32'h5555_BEEF, 32'd0, 0,
                      1'b1, 30'h4, 4'b0011, 32'hBEEF_BEEF, 32'd0, 1'b0);
        applyStimulus(2'b11, 3'd0, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 0,
                      1'b1, 30'h8, 4'b1111, 32'hCAFE_F00D, 32'd0, 1'b0);
        applyStimulus(2'b00, 3'd0, 32'h0000_0002, 32'd0, 32'h1234_8078, 3,
                      1'b1, 30'h0, 4'b0000, 32'd0, 32'hFFFF_FF80, 1'b0);
        applyStimulus(2'b00, 3'd3, 32'h0000_0002, 32'd0, 32'h1234_8078, 3,
                      1'b1, 30'h0, 4'b0000, 32'd0, 32'h0000_0080, 1'b0);
        applyStimulus(2'b00, 3'd1, 32'h0000_0002, 32'd0, 32'h1234_ABCD, 1,
                      1'b1, 30'h0, 4'b0000, 32'd0, 32'hFFFF_ABCD, 1'b0);
        applyStimulus(2'b00, 3'd4, 32'h0000_0002, 32'd0, 32'h1234_ABCD, 2,
                      1'b1, 30'h0, 4'b0000, 32'd0, 32'h0000_ABCD, 1'b0);
        applyStimulus(2'b00, 3'd2, 32'h0000_0000, 32'd0, 32'h1234_ABCD, 1,
                      1'b1, 30'h0, 4'b0000, 32'd0, 32'h1234_ABCD, 1'b0);

        $display("[TB] illegal mask, timeout and data-at-timeout");
        applyStimulus(2'b00, 3'd5, 32'h0000_0040, 32'd0, 32'd0, 0,
                      1'b0, 30'h0, 4'b0000, 32'd0, 32'd0, 1'b1);
        applyStimulus(2'b00, 3'd2, 32'h0000_0100, 32'd0, 32'd0, -1,
                      1'b1, 30'h40, 4'b0000, 32'd0, 32'd0, 1'b1);
        applyStimulus(2'b00, 3'd2, 32'h0000_0104, 32'd0, 32'h8765_4321, TO,
                      1'b1, 30'h41, 4'b0000, 32'd0, 32'h8765_4321, 1'b0);

        $display("[TB] misaligned accesses");
`ifdef MEMACC_MISALIGN_TRAP_EN
        applyStimulus(2'b00, 3'd2, 32'h0000_0006, 32'd0, 32'h1234_ABCD, 2,
                      1'b0, 30'h0, 4'b0000, 32'd0, 32'd0, 1'b1);
        applyStimulus(2'b10, 3'd0, 32'h0000_0003, 32'h0000_1234, 32'd0, 0,
                      1'b0, 30'h0, 4'b0000, 32'd0, 32'd0, 1'b1);
`else
        applyStimulus(2'b00, 3'd2, 32'h0000_0006, 32'd0, 32'h1234_ABCD, 2,
                      1'b1, 30'h1, 4'b0000, 32'd0, 32'h1234_ABCD, 1'b0);
        applyStimulus(2'b10, 3'd0, 32'h0000_0003, 32'h0000_1234, 32'd0, 0,
                      1'b1, 30'h0, 4'b0011, 32'h1234_1234, 32'd0, 1'b0);
`endif

        $display("[TB] reset during WAIT");
        @(negedge clk);
        req_valid = 1'b1;
        MemWrite  = 2'b00;
        Mask      = 3'd2;
        addr      = 32'h0000_0200;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkResetOutputs("midwait");
        @(posedge clk);
        #1 rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("stale");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 12; i++) begin
            mw  = 2'($urandom_range(0, 3));
            mk  = 3'($urandom_range(0, 4));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            lat = $urandom_range(1, 5);
            if ((mw == 2'b00 && (mk == 3'd1 || mk == 3'd4)) || mw == 2'b10)
                a[0] = 1'b0;
            if ((mw == 2'b00 && mk == 3'd2) || mw == 2'b11)
                a[1:0] = 2'b00;
            modelStore(mw, a[1:0], wd, we, sd);
            ed = (mw == 2'b00) ? modelLoad(mk, a[1:0], rd) : 32'd0;
            applyStimulus(mw, mk, a, wd, rd, lat, 1'b1, a[31:2], we, sd, ed, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
